// File: rtl/mpsk_phase_accum.sv
// mpsk_phase_accum
//   Phase accumulator and M-sequence phase modulator that produces sine ROM
//   addresses for a pulsed MPSK packet. A packet is NUM_OF_IMP impulses of
//   IMP_SAMPLES modulated samples, each followed (except the last) by zero
//   samples up to PERIOD_SAMPLES. Every impulse restarts the accumulator, the
//   chip counter and the M-sequence.
//
// Optional feature: define MPSK_PHASE_ACCUM_QPSK_EN to make MODE select QPSK
//   (two M-sequence bits per chip). Without it MODE is ignored and the block
//   is BPSK only.
//
// Ports
//   CLK             in   sole clock, rising edge
//   RESET_N         in   asynchronous active-low reset
//   SIGNAL_TYPE     in   generator select, start honoured only for PSK_SIGNAL_TYPE
//   MODE            in   0 = BPSK, 1 = QPSK
//   FTW             in   frequency tuning word
//   IMP_SAMPLES     in   samples per impulse
//   PERIOD_SAMPLES  in   samples per impulse period
//   CHIP_SAMPLES    in   samples per chip (0 behaves as 1)
//   NUM_OF_IMP      in   impulses per packet
//   SIGN_START_GEN  in   start request
//   OUT_REG_READY   in   downstream ready; low stalls the generator
//   ROM_ADDRESS     out  sine ROM address
//   ADDR_VALID      out  ROM_ADDRESS carries a sample this cycle
//   BUSY            out  packet in progress
//   SIGN_START_CALC out  pulse on the first sample of the packet
//   SIGN_STOP_CALC  out  high on the last sample of the packet
//   START_ERR       out  one-cycle pulse when a start is rejected
`default_nettype none

module mpsk_phase_accum #(
  parameter int unsigned           ACC_WIDTH       = 32,
  parameter int unsigned           ADDR_WIDTH      = 12,
  parameter int unsigned           LFSR_ORDER      = 10,
  parameter int unsigned           LFSR_TAP        = 6,
  parameter logic [LFSR_ORDER-1:0] LFSR_SEED       = 10'b0000001001,
  parameter logic [1:0]            PSK_SIGNAL_TYPE = 2'd2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [1:0]            SIGNAL_TYPE,
  input  logic                  MODE,
  input  logic [ACC_WIDTH-1:0]  FTW,
  input  logic [23:0]           IMP_SAMPLES,
  input  logic [26:0]           PERIOD_SAMPLES,
  input  logic [15:0]           CHIP_SAMPLES,
  input  logic [4:0]            NUM_OF_IMP,
  input  logic                  SIGN_START_GEN,
  input  logic                  OUT_REG_READY,
  output logic [ADDR_WIDTH-1:0] ROM_ADDRESS,
  output logic                  ADDR_VALID,
  output logic                  BUSY,
  output logic                  SIGN_START_CALC,
  output logic                  SIGN_STOP_CALC,
  output logic                  START_ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_t;

  state_t state_q, state_d;

  // Latched packet configuration
  logic [ACC_WIDTH-1:0]  ftw_q;
  logic [23:0]           imp_q;
  logic [26:0]           period_q;
  logic [15:0]           chip_q;
  logic [31:0]           pkt_len_q;

  // Running state
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [26:0]           period_cnt_q;
  logic [15:0]           chip_cnt_q;
  logic [31:0]           samp_cnt_q;
  logic [LFSR_ORDER-1:0] lfsr_q;
  logic                  start_err_q;

  // Control strobes from the FSM
  logic start_req;
  logic cfg_bad;
  logic accept;
  logic reject;
  logic consume;
  logic enter_on;
  logic last_sample;
  logic imp_end;
  logic period_end;
  logic qpsk;

  logic [31:0]           pkt_len_calc;
  logic [ADDR_WIDTH-1:0] phase_off;

  function automatic logic [LFSR_ORDER-1:0] lfsr_step(input logic [LFSR_ORDER-1:0] r);
    return {r[LFSR_ORDER-2:0], r[LFSR_TAP] ^ r[LFSR_ORDER-1]};
  endfunction

`ifdef MPSK_PHASE_ACCUM_QPSK_EN
  logic mode_q;
  assign qpsk = mode_q;
`else
  logic mode_unused;
  assign mode_unused = MODE;
  assign qpsk        = 1'b0;
`endif

  assign start_req    = SIGN_START_GEN && OUT_REG_READY && (SIGNAL_TYPE == PSK_SIGNAL_TYPE);
  assign cfg_bad      = (NUM_OF_IMP == 5'd0) || (IMP_SAMPLES == 24'd0) ||
                        (PERIOD_SAMPLES < 27'(IMP_SAMPLES));
  assign pkt_len_calc = (32'(NUM_OF_IMP) - 32'd1) * 32'(PERIOD_SAMPLES) + 32'(IMP_SAMPLES);

  assign consume      = (state_q != S_IDLE) && OUT_REG_READY;
  assign last_sample  = (samp_cnt_q == pkt_len_q - 32'd1);
  assign imp_end      = (period_cnt_q == 27'(imp_q) - 27'd1);
  assign period_end   = (period_cnt_q == period_q - 27'd1);

  // BPSK uses the current M-sequence output as the MSB of the offset; QPSK
  // additionally uses the next output, which already sits one bit below.
  always_comb begin
    phase_off                 = '0;
    phase_off[ADDR_WIDTH-1]   = lfsr_q[LFSR_ORDER-1];
    if (qpsk) begin
      phase_off[ADDR_WIDTH-2] = lfsr_q[LFSR_ORDER-2];
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    reject          = 1'b0;
    enter_on        = 1'b0;
    ROM_ADDRESS     = '0;
    ADDR_VALID      = consume;
    BUSY            = (state_q != S_IDLE);
    SIGN_START_CALC = consume && (samp_cnt_q == 32'd0);
    SIGN_STOP_CALC  = consume && last_sample;
    START_ERR       = start_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_req) begin
          if (cfg_bad) begin
            reject  = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_ON;
          end
        end
      end

      S_ON: begin
        ROM_ADDRESS = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + phase_off;
        if (consume && imp_end) begin
          if (last_sample) begin
            state_d = S_IDLE;
          end else if (period_q == 27'(imp_q)) begin
            // No gap between impulses: restart the impulse directly.
            enter_on = 1'b1;
          end else begin
            state_d = S_OFF;
          end
        end
      end

      S_OFF: begin
        if (consume && period_end) begin
          state_d  = S_ON;
          enter_on = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Configuration latch and datapath
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ftw_q        <= '0;
      imp_q        <= '0;
      period_q     <= '0;
      chip_q       <= '0;
      pkt_len_q    <= '0;
      acc_q        <= '0;
      period_cnt_q <= '0;
      chip_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      lfsr_q       <= LFSR_SEED;
      start_err_q  <= 1'b0;
`ifdef MPSK_PHASE_ACCUM_QPSK_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      start_err_q <= reject;
      if (accept) begin
        ftw_q        <= FTW;
        imp_q        <= IMP_SAMPLES;
        period_q     <= PERIOD_SAMPLES;
        chip_q       <= (CHIP_SAMPLES == 16'd0) ? 16'd1 : CHIP_SAMPLES;
        pkt_len_q    <= pkt_len_calc;
`ifdef MPSK_PHASE_ACCUM_QPSK_EN
        mode_q       <= MODE;
`endif
        acc_q        <= '0;
        chip_cnt_q   <= '0;
        lfsr_q       <= lfsr_step(LFSR_SEED);
        period_cnt_q <= '0;
        samp_cnt_q   <= '0;
      end else if (consume) begin
        samp_cnt_q <= samp_cnt_q + 32'd1;
        if (enter_on) begin
          acc_q        <= '0;
          chip_cnt_q   <= '0;
          lfsr_q       <= lfsr_step(LFSR_SEED);
          period_cnt_q <= '0;
        end else begin
          period_cnt_q <= period_cnt_q + 27'd1;
          if (state_q == S_ON) begin
            acc_q <= acc_q + ftw_q;
            if (chip_cnt_q == chip_q - 16'd1) begin
              chip_cnt_q <= '0;
              lfsr_q     <= qpsk ? lfsr_step(lfsr_step(lfsr_q)) : lfsr_step(lfsr_q);
            end else begin
              chip_cnt_q <= chip_cnt_q + 16'd1;
            end
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mpsk_phase_accum.sv
module tb_mpsk_phase_accum;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [1:0]  SIGNAL_TYPE = '0;
  logic        MODE = 1'b0;
  logic [31:0] FTW = '0;
  logic [23:0] IMP_SAMPLES = '0;
  logic [26:0] PERIOD_SAMPLES = '0;
  logic [15:0] CHIP_SAMPLES = '0;
  logic [4:0]  NUM_OF_IMP = '0;
  logic        SIGN_START_GEN = 1'b0;
  logic        OUT_REG_READY = 1'b0;
  logic [11:0] ROM_ADDRESS;
  logic        ADDR_VALID;
  logic        BUSY;
  logic        SIGN_START_CALC;
  logic        SIGN_STOP_CALC;
  logic        START_ERR;

  mpsk_phase_accum dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .SIGNAL_TYPE    (SIGNAL_TYPE),
    .MODE           (MODE),
    .FTW            (FTW),
    .IMP_SAMPLES    (IMP_SAMPLES),
    .PERIOD_SAMPLES (PERIOD_SAMPLES),
    .CHIP_SAMPLES   (CHIP_SAMPLES),
    .NUM_OF_IMP     (NUM_OF_IMP),
    .SIGN_START_GEN (SIGN_START_GEN),
    .OUT_REG_READY  (OUT_REG_READY),
    .ROM_ADDRESS    (ROM_ADDRESS),
    .ADDR_VALID     (ADDR_VALID),
    .BUSY           (BUSY),
    .SIGN_START_CALC(SIGN_START_CALC),
    .SIGN_STOP_CALC (SIGN_STOP_CALC),
    .START_ERR      (START_ERR)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  bit          prbs[0:127];
  logic [31:0] cfg_ftw;
  int unsigned cfg_imp, cfg_per, cfg_chip;
  bit          cfg_qpsk;
  logic [11:0] cap[0:255];
  int          stop_at;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Chip stream as a linear recurrence: s[j] = s[j-7] ^ s[j-10], seeded with
  // the seed bits MSB first. Chip c of an impulse uses s[1+c] (BPSK) or the
  // pair s[1+2c], s[2+2c] (QPSK).
  task automatic build_prbs();
    logic [9:0] seed;
    seed = 10'b0000001001;
    for (int j = 0; j < 10; j++) prbs[j] = seed[9-j];
    for (int j = 10; j < 128; j++) prbs[j] = prbs[j-7] ^ prbs[j-10];
  endtask

  function automatic logic [31:0] exp_addr(input int unsigned t);
    int unsigned k, c, off;
    logic [31:0] ph;
    k = t % cfg_per;
    if (k >= cfg_imp) return 32'd0;
    ph = k * cfg_ftw;
    c  = k / cfg_chip;
    if (cfg_qpsk) off = (prbs[1+2*c] ? 2048 : 0) + (prbs[2+2*c] ? 1024 : 0);
    else          off = prbs[1+c] ? 2048 : 0;
    return ((ph >> 20) + off) % 4096;
  endfunction

  function automatic logic [11:0] off_of(input int unsigned k);
    return cap[k] - 12'(k * 256);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, ROM_ADDRESS, 0);
    check({tag, "_valid"}, ADDR_VALID, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_startc"}, SIGN_START_CALC, 0);
    check({tag, "_stopc"}, SIGN_STOP_CALC, 0);
    check({tag, "_err"}, START_ERR, 0);
  endtask

  // stall: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles at sample 4
  task automatic run_packet(input logic [31:0] ftw, input int unsigned imp, input int unsigned per,
                            input int unsigned chip, input int unsigned n, input bit mode,
                            input int stall, input int abort_at);
    int unsigned len, t, cyc, stalls;
    bit ready;
    cfg_ftw  = ftw;
    cfg_imp  = imp;
    cfg_per  = per;
    cfg_chip = (chip == 0) ? 1 : chip;
`ifdef MPSK_PHASE_ACCUM_QPSK_EN
    cfg_qpsk = mode;
`else
    cfg_qpsk = 1'b0;
`endif
    len     = (n - 1) * per + imp;
    stop_at = -1;

    @(negedge CLK);
    FTW = ftw; IMP_SAMPLES = 24'(imp); PERIOD_SAMPLES = 27'(per);
    CHIP_SAMPLES = 16'(chip); NUM_OF_IMP = 5'(n); MODE = mode;
    SIGNAL_TYPE = 2'd2; SIGN_START_GEN = 1'b1; OUT_REG_READY = 1'b1;
    #1 check("pre_busy", BUSY, 0);
    @(negedge CLK);
    t = 0; cyc = 0; stalls = 0;
    while (t < len && cyc < len * 20 + 100) begin
      case (stall)
        1:       ready = ($urandom % 4) != 0;
        2: begin
          if (t == 4 && stalls < 3) begin ready = 1'b0; stalls++; end
          else ready = 1'b1;
        end
        default: ready = 1'b1;
      endcase
      OUT_REG_READY  = ready;
      // Inputs wander mid-packet; the latched configuration must not move.
      SIGN_START_GEN = 1'($urandom % 2);
      FTW            = $urandom;
      IMP_SAMPLES    = 24'($urandom % 4);
      #1;
      if (abort_at >= 0 && t == 32'(abort_at) && ready) begin
        RESET_N = 1'b0;
        #1 check_all_zero("rst_mid");
        SIGN_START_GEN = 1'b0;
        return;
      end
      check("busy", BUSY, 1);
      check("valid", ADDR_VALID, ready);
      check("err_busy", START_ERR, 0);
      if (ready) begin
        check("addr", ROM_ADDRESS, exp_addr(t));
        check("start_calc", SIGN_START_CALC, t == 0);
        check("stop_calc", SIGN_STOP_CALC, t == len - 1);
        if (t < 256) cap[t] = ROM_ADDRESS;
        if (SIGN_STOP_CALC) stop_at = t;
        t++;
      end
      cyc++;
      @(negedge CLK);
    end
    SIGN_START_GEN = 1'b0;
    OUT_REG_READY  = 1'b1;
    check("valid_count", t, len);
    #1;
    check("end_valid", ADDR_VALID, 0);
    check("end_busy", BUSY, 0);
    if (stall == 2) check("stall_cycles", stalls, 3);
  endtask

  task automatic err_start(input int unsigned imp, input int unsigned per, input int unsigned n,
                           input logic [1:0] typ, input bit exp_err);
    @(negedge CLK);
    IMP_SAMPLES = 24'(imp); PERIOD_SAMPLES = 27'(per); NUM_OF_IMP = 5'(n);
    CHIP_SAMPLES = 16'd2; SIGNAL_TYPE = typ; SIGN_START_GEN = 1'b1; OUT_REG_READY = 1'b1;
    @(negedge CLK);
    SIGN_START_GEN = 1'b0;
    #1;
    check("err_pulse", START_ERR, exp_err);
    check("err_busy0", BUSY, 0);
    check("err_valid0", ADDR_VALID, 0);
    @(negedge CLK);
    #1;
    check("err_clear", START_ERR, 0);
    check("err_busy1", BUSY, 0);
  endtask

  initial begin
    build_prbs();

    // Reset state
    #12 check_all_zero("rst");
    @(negedge CLK);
    RESET_N = 1'b1;

    // BPSK reference packet: 20 samples, gap at 8..11
    run_packet(32'h1000_0000, 8, 12, 2, 2, 1'b0, 0, -1);
    check("t1_s0", cap[0], 0);
    check("t1_s1", cap[1], 256);
    check("t1_s2", cap[2], 512);
    check("t1_s3", cap[3], 768);
    for (int k = 8; k < 12; k++) check("t1_gap", cap[k], 0);
    check("t1_s12", cap[12], 0);
    check("t1_stop", 32'(stop_at), 19);

    // Chip 4 -> chip 5 flips the M-sequence bit from 0 to 1
    run_packet(32'h1000_0000, 16, 16, 2, 1, 1'b0, 0, -1);
    check("chip_pre", off_of(9), 0);
    check("chip_jump", off_of(10), 2048);

    // MODE=1, chip length 4: offsets on a 1024 grid, constant within a chip
    run_packet(32'h1000_0000, 16, 16, 4, 1, 1'b1, 0, -1);
    for (int k = 0; k < 16; k++) begin
      check("q_grid", 32'(off_of(k) % 1024), 0);
      check("q_hold", off_of(k), off_of(k & ~3));
    end

    // Three-cycle stall mid-impulse
    run_packet(32'h1000_0000, 8, 12, 2, 2, 1'b0, 2, -1);
    check("stall_s5", cap[5], 5 * 256);

    // Rejected starts and wrong generator type
    err_start(8, 4, 2, 2'd2, 1'b1);
    err_start(0, 4, 1, 2'd2, 1'b1);
    err_start(4, 8, 0, 2'd2, 1'b1);
    err_start(4, 8, 1, 2'd1, 1'b0);

    // Reset at sample 5, then restart from scratch
    run_packet(32'h1000_0000, 8, 12, 2, 2, 1'b0, 0, 5);
    @(negedge CLK);
    check_all_zero("rst_hold");
    RESET_N = 1'b1;
    run_packet(32'h1000_0000, 8, 12, 2, 2, 1'b0, 0, -1);
    check("rst_s0", cap[0], 0);
    check("rst_s1", cap[1], 256);

    // Randomized packets
    for (int i = 0; i < 25; i++) begin
      int unsigned imp, per;
      imp = 1 + $urandom % 24;
      per = imp + $urandom % 8;
      run_packet($urandom, imp, per, $urandom % 6, 1 + $urandom % 4,
                 1'($urandom % 2), $urandom % 2, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
